int_issue_queue: RTL and testbench

Operand/opcode issue queue and writeback aligner directly upstream of the integer unit (INTU) in each SIMD lane. It buffers up to DEPTH integer instructions from the decode/operand-fetch stage, issues at most one per cycle to INTU, and tracks INTU's one-cycle registered latency. It captures each result, tagged with its destination, in a 2-entry result buffer and presents it to writeback with a valid/ready handshake. INTU itself cannot stall, so all backpressure is absorbed here.

---
 rtl/OpCodes.sv | 14 +
 rtl/int_issue_queue_if.sv | 40 ++++
 rtl/int_issue_queue.sv | 141 ++++++++++++++
 tb/tb_int_issue_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/OpCodes.sv
// Opcode set and data-width constant shared by the lane datapath.
package OpCodes;

   localparam int NSIG = 15;

   typedef enum logic [2:0] {
      IADD = 3'd0,
      IMUL = 3'd1,
      LD   = 3'd2,
      ST   = 3'd3,
      NOP  = 3'd4
   } opcode;

endpackage

// File: rtl/int_issue_queue_if.sv
// Bundle of the upstream, INTU and writeback signals around int_issue_queue.
// The slave modport is the queue itself; master is its environment.
interface int_issue_queue_if #(
   parameter int TAGW = 4
);

   // upstream instruction stream
   logic                       in_valid;
   logic                       in_ready;
   OpCodes::opcode             in_op;
   logic [OpCodes::NSIG:0]     in_a;
   logic [OpCodes::NSIG:0]     in_b;
   logic [TAGW-1:0]            in_tag;

   // INTU side
   OpCodes::opcode             intu_op;
   logic [OpCodes::NSIG:0]     intu_a;
   logic [OpCodes::NSIG:0]     intu_b;
   logic [OpCodes::NSIG:0]     intu_out;

   // writeback side
   logic                       wb_valid;
   logic                       wb_ready;
   logic [OpCodes::NSIG:0]     wb_data;
   logic [TAGW-1:0]            wb_tag;
   logic                       wb_err;

   logic                       busy;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, intu_out, wb_ready,
      output in_ready, intu_op, intu_a, intu_b, wb_valid, wb_data, wb_tag, wb_err, busy
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, intu_out, wb_ready,
      input  in_ready, intu_op, intu_a, intu_b, wb_valid, wb_data, wb_tag, wb_err, busy
   );

endinterface

// File: rtl/int_issue_queue.sv
// Integer issue queue and writeback aligner in front of the lane's INTU.
// Instructions queue in order and issue one per cycle. INTU's registered
// result is captured one cycle after issue into a 2-entry result FIFO.
// Issue is throttled so that this FIFO can never overflow, because INTU
// cannot be stalled.
module int_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic                clk,
   input  logic                rst,
   int_issue_queue_if.slave    bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = OpCodes::NSIG + 1;
   localparam logic [AW:0] QFULL = (AW+1)'(DEPTH);

   // instruction queue storage and pointers
   OpCodes::opcode    q_op  [DEPTH];
   logic [DW-1:0]     q_a   [DEPTH];
   logic [DW-1:0]     q_b   [DEPTH];
   logic [TAGW-1:0]   q_tag [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       qcount;

   // in-flight slot that tracks INTU's one-cycle latency
   logic              inflight;
   logic [TAGW-1:0]   if_tag;
   logic              if_err;

   // 2-entry result FIFO
   logic [DW-1:0]     r_data [2];
   logic [TAGW-1:0]   r_tag  [2];
   logic              r_err  [2];
   logic              r_wr, r_rd;
   logic [1:0]        rcount;

   logic              push, issue, wb_fire, head_ok;
   logic [2:0]        occ, occ_limit;

   assign bus.in_ready = !rst && (qcount < QFULL);
   assign push         = bus.in_valid && bus.in_ready;
   assign bus.wb_valid = (rcount != 2'd0);
   assign wb_fire      = bus.wb_valid && bus.wb_ready;

   // Results buffered plus in flight, less the one leaving this cycle, must
   // stay below 2. That way the capture slot next cycle is always free.
   assign occ       = {1'b0, rcount} + {2'b00, inflight};
   assign occ_limit = 3'd2 + {2'b00, wb_fire};
   assign issue     = (qcount != '0) && (occ < occ_limit);
   assign head_ok   = (q_op[rd_ptr] == OpCodes::IADD) || (q_op[rd_ptr] == OpCodes::IMUL);

   // Drive INTU from the issuing head entry, otherwise with idle values.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      bus.intu_op = OpCodes::IADD;
      bus.intu_a  = '0;
      bus.intu_b  = '0;
      if (issue && head_ok) begin
         bus.intu_op = q_op[rd_ptr];
         bus.intu_a  = q_a[rd_ptr];
         bus.intu_b  = q_b[rd_ptr];
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         qcount <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         case ({push, issue})
            2'b10:   qcount <= qcount + 1'b1;
            2'b01:   qcount <= qcount - 1'b1;
            default: qcount <= qcount;
         endcase
      end
   end

   // Queue payload write.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are not reset; pointers and counts alone decide which entries are live.
      if (push) begin
         q_op[wr_ptr]  <= bus.in_op;
         q_a[wr_ptr]   <= bus.in_a;
         q_b[wr_ptr]   <= bus.in_b;
         q_tag[wr_ptr] <= bus.in_tag;
      end
   end

   // In-flight flag, set for the one cycle INTU is computing.
   always_ff @(posedge clk) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= issue;
   end

   // In-flight tag and error flag carried alongside the INTU computation.
   always_ff @(posedge clk) begin
      if (issue) begin
         if_tag <= q_tag[rd_ptr];
         if_err <= !head_ok;
      end
   end

   // Result FIFO pointers and occupancy; capture and writeback may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr   <= 1'b0;
         r_rd   <= 1'b0;
         rcount <= 2'd0;
      end else begin
         if (inflight) r_wr <= ~r_wr;
         if (wb_fire)  r_rd <= ~r_rd;
         case ({inflight, wb_fire})
            2'b10:   rcount <= rcount + 1'b1;
            2'b01:   rcount <= rcount - 1'b1;
            default: rcount <= rcount;
         endcase
      end
   end

   // Capture INTU's result, forced to zero for unsupported opcodes.
   always_ff @(posedge clk) begin
      if (inflight) begin
         r_data[r_wr] <= if_err ? '0 : bus.intu_out;
         r_tag[r_wr]  <= if_tag;
         r_err[r_wr]  <= if_err;
      end
   end

   assign bus.wb_data = r_data[r_rd];
   assign bus.wb_tag  = r_tag[r_rd];
   assign bus.wb_err  = r_err[r_rd];
   assign bus.busy    = (qcount != '0) || inflight || (rcount != 2'd0);

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed self-checking bench for int_issue_queue with a behavioural
// one-cycle INTU. Inputs change 1 time unit after posedge; outputs are
// sampled at negedge.
module tb_int_issue_queue;
   import OpCodes::*;

   localparam int W = NSIG + 1;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   int_issue_queue_if #(.TAGW(4)) bus ();

   int_issue_queue #(.DEPTH(4), .TAGW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural INTU: registered add/multiply, modulo 2^W.
   always @(posedge clk) begin
      if (bus.intu_op == IMUL) bus.intu_out <= bus.intu_a * bus.intu_b;
      else                     bus.intu_out <= bus.intu_a + bus.intu_b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic send(input opcode op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] tag);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_op    = IADD;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_tag   = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] exp_data [3];
      logic [3:0]   exp_tag  [3];
      int  nxt, got, stale;
      bit  acc;

      exp_data[0] = W'(42);     exp_tag[0] = 4'd1;
      exp_data[1] = W'(4);      exp_tag[1] = 4'd2;
      exp_data[2] = W'('hFFFE); exp_tag[2] = 4'd3;

      // ---------------- reset; an in_valid during rst must be ignored
      rst          = 1'b1;
      bus.wb_ready = 1'b1;
      idle();
      next();
      send(IADD, W'(1), W'(1), 4'd15);
      mid();
      check("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
      next();
      rst = 1'b0;
      idle();
      mid();
      check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_intu_op",  32'(bus.intu_op),  32'(IADD));
      check("rst_intu_a",   32'(bus.intu_a),   32'd0);
      next();

      // ---------------- single IADD 3+4, tag 5: wb_valid in cycle 3
      send(IADD, W'(3), W'(4), 4'd5);
      next();
      idle();
      mid();
      check("lat_issue_op", 32'(bus.intu_op), 32'(IADD));
      check("lat_issue_a",  32'(bus.intu_a),  32'd3);
      check("lat_issue_b",  32'(bus.intu_b),  32'd4);
      check("lat_c1_valid", 32'(bus.wb_valid), 32'd0);
      next();
      mid();
      check("lat_c2_valid", 32'(bus.wb_valid), 32'd0);
      check("lat_c2_busy",  32'(bus.busy),     32'd1);
      next();
      mid();
      check("lat_c3_valid", 32'(bus.wb_valid), 32'd1);
      check("lat_c3_data",  32'(bus.wb_data),  32'd7);
      check("lat_c3_tag",   32'(bus.wb_tag),   32'd5);
      check("lat_c3_err",   32'(bus.wb_err),   32'd0);
      next();
      mid();
      check("lat_c4_valid", 32'(bus.wb_valid), 32'd0);
      check("lat_c4_busy",  32'(bus.busy),     32'd0);
      next();

      // ---------------- back-to-back IMUL/IADD/IMUL with wrap
      send(IMUL, W'(6), W'(7), 4'd1);
      next();
      send(IADD, W'(2), W'(2), 4'd2);
      mid();
      check("b2b_issue_op", 32'(bus.intu_op), 32'(IMUL));
      next();
      send(IMUL, W'('hFFFF), W'(2), 4'd3);
      next();
      idle();
      for (int i = 0; i < 3; i++) begin
         mid();
         check($sformatf("b2b_valid_%0d", i), 32'(bus.wb_valid), 32'd1);
         check($sformatf("b2b_data_%0d", i),  32'(bus.wb_data),  32'(exp_data[i]));
         check($sformatf("b2b_tag_%0d", i),   32'(bus.wb_tag),   32'(exp_tag[i]));
         next();
      end
      mid();
      check("b2b_after_valid", 32'(bus.wb_valid), 32'd0);
      next();

      // ---------------- backpressure: 8 IADDs (i + 100, tag i), wb_ready = 0
      bus.wb_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(IADD, W'(i), W'(100), 4'(i));
         mid();
         check($sformatf("bp_ready_%0d", i), 32'(bus.in_ready), 32'd1);
         next();
      end
      send(IADD, W'(6), W'(100), 4'd6);
      for (int i = 0; i < 2; i++) begin
         mid();
         check($sformatf("bp_full_ready_%0d", i), 32'(bus.in_ready), 32'd0);
         check($sformatf("bp_hold_valid_%0d", i), 32'(bus.wb_valid), 32'd1);
         check($sformatf("bp_hold_data_%0d", i),  32'(bus.wb_data),  32'd100);
         check($sformatf("bp_hold_tag_%0d", i),   32'(bus.wb_tag),   32'd0);
         next();
      end
      bus.wb_ready = 1'b1;
      nxt = 6;
      got = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (nxt < 8) send(IADD, W'(nxt), W'(100), 4'(nxt));
         else         idle();
         mid();
         if (bus.wb_valid) begin
            if (got < 8) begin
               check($sformatf("bp_drain_tag_%0d", got),  32'(bus.wb_tag),  32'(got));
               check($sformatf("bp_drain_data_%0d", got), 32'(bus.wb_data), 32'(100 + got));
            end
            got++;
         end
         acc = bus.in_valid && bus.in_ready;
         next();
         if (acc) nxt++;
      end
      idle();
      check("bp_all_accepted", 32'(nxt), 32'd8);
      check("bp_result_count", 32'(got), 32'd8);

      // ---------------- unsupported LD between two IADDs
      send(IADD, W'(1), W'(1), 4'd8);
      next();
      send(LD, W'(5), W'(5), 4'd9);
      next();
      send(IADD, W'(2), W'(3), 4'd10);
      mid();
      check("ld_idle_op", 32'(bus.intu_op), 32'(IADD));
      check("ld_idle_a",  32'(bus.intu_a),  32'd0);
      check("ld_idle_b",  32'(bus.intu_b),  32'd0);
      next();
      idle();
      mid();
      check("ld_r0_valid", 32'(bus.wb_valid), 32'd1);
      check("ld_r0_data",  32'(bus.wb_data),  32'd2);
      check("ld_r0_tag",   32'(bus.wb_tag),   32'd8);
      check("ld_r0_err",   32'(bus.wb_err),   32'd0);
      next();
      mid();
      check("ld_r1_valid", 32'(bus.wb_valid), 32'd1);
      check("ld_r1_data",  32'(bus.wb_data),  32'd0);
      check("ld_r1_tag",   32'(bus.wb_tag),   32'd9);
      check("ld_r1_err",   32'(bus.wb_err),   32'd1);
      next();
      mid();
      check("ld_r2_valid", 32'(bus.wb_valid), 32'd1);
      check("ld_r2_data",  32'(bus.wb_data),  32'd5);
      check("ld_r2_tag",   32'(bus.wb_tag),   32'd10);
      check("ld_r2_err",   32'(bus.wb_err),   32'd0);
      next();
      mid();
      check("ld_after_busy", 32'(bus.busy), 32'd0);
      next();

      // ---------------- reset with 3 queued and 2 buffered
      bus.wb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(IADD, W'(i), W'(50), 4'(i + 1));
         mid();
         check($sformatf("mr_ready_%0d", i), 32'(bus.in_ready), 32'd1);
         next();
      end
      rst = 1'b1;
      send(IADD, W'(9), W'(9), 4'd14);
      mid();
      check("mr_pre_valid", 32'(bus.wb_valid), 32'd1);
      check("mr_pre_busy",  32'(bus.busy),     32'd1);
      check("mr_rst_ready", 32'(bus.in_ready), 32'd0);
      next();
      rst = 1'b0;
      idle();
      bus.wb_ready = 1'b1;
      mid();
      check("mr_post_busy",  32'(bus.busy),     32'd0);
      check("mr_post_valid", 32'(bus.wb_valid), 32'd0);
      check("mr_post_ready", 32'(bus.in_ready), 32'd1);
      next();
      stale = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         mid();
         if (bus.wb_valid || bus.busy) stale++;
         next();
      end
      check("mr_no_stale", 32'(stale), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
